grid_mem_arbiter: RTL
=====================

Name: grid_mem_arbiter

Overview:
Round-robin arbiter sharing the single-port 256x8 grid memory between the piece placer, the piece mover and the line clearer. A requester holds its grant for a whole burst, e.g. the placer's 12-cell next-piece write to addresses 240-251. The arbiter muxes the owner's we/addr/data onto the memory and routes 1-cycle-latency read data back. A watchdog revokes grants that exceed a cycle budget.

Parameters:
NUM_REQ, 3, number of requesters (index 0 = placer, 1 = mover, 2 = line clearer)
ADDR_W, 8, grid memory address width
DATA_W, 8, grid cell data width
HOLD_MAX, 64, maximum consecutive granted cycles before forced revoke (>= 2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester access request; level, held for the whole burst
req_we  in  NUM_REQ  per-requester write enable
req_addr  in  NUM_REQ*ADDR_W  per-requester address, flattened, requester i at [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  per-requester write data, flattened
gnt  out  NUM_REQ  one-hot grant, registered
mem_we  out  1  grid memory write enable
mem_addr  out  ADDR_W  grid memory address
mem_data  out  DATA_W  grid memory write data
mem_rdata  in  DATA_W  grid memory read data, valid 1 cycle after address
rdata  out  DATA_W  read data broadcast to all requesters (= mem_rdata)
rvalid  out  NUM_REQ  one-hot read-data-valid strobe
timeout_err  out  1  one-cycle pulse when a grant is revoked by the watchdog

Behaviour:
- Reset: gnt=0, rvalid=0, timeout_err=0, hold counter=0, RR pointer=0, state=IDLE. mem_we=0, mem_addr=0, mem_data=0 whenever no grant is held.
- FSM states: IDLE, OWN.
- IDLE: if any req, pick the winner by round-robin, searching from the RR pointer upward with wrap. Next edge: gnt[winner]=1, state=OWN, counter=1. With no req, stay in IDLE.
- Grant latency: req sampled high at edge N gives gnt high after edge N+1. The requester must not drive accesses until it sees gnt.
- OWN, owner o:
  - mem_we = req[o] & req_we[o]; mem_addr and mem_data are the owner's fields. These are combinational from the inputs and gated by gnt.
  - Release: when req[o] is low, the RR pointer becomes o+1 (mod NUM_REQ) and the same cycle re-arbitrates among the other requests. The next grant appears on the following edge with no dead cycle. If nothing is pending, go to IDLE and gnt=0.
  - Watchdog: the counter increments every OWN cycle. When it equals HOLD_MAX and req[o] is still high: gnt=0 next edge, timeout_err pulses for 1 cycle, pointer = o+1, state=IDLE. The revoked requester is eligible again after one IDLE cycle, at the lowest RR priority.
- Read path: rvalid[i] is registered as gnt[i] & req[i] & ~req_we[i]. It pulses the cycle after each read-address cycle, so back-to-back reads give back-to-back rvalid. rdata passes mem_rdata through unchanged.
- Simultaneous events: a release and a new request in the same cycle are arbitrated normally. A request from the current owner in its own release cycle is ignored. Multiple requests in IDLE are resolved by the RR pointer only.
- Reset mid-burst: the grant is dropped immediately on the reset edge. Memory writes stop that cycle, and no timeout_err is raised.
- Invariants: gnt is always one-hot or zero, and mem_we is never asserted with gnt=0.

Decomposition:
- Shared package: NUM_REQ, the index constants REQ_PLACER=0, REQ_MOVER=1 and REQ_CLEAR=2, GRID_ADDR_W=8, GRID_DATA_W=8, NEXT_PIECE_BASE_ADDR=240, and the FSM state encoding.
- One sub-module, rr_pick: a combinational round-robin picker that takes the request vector and pointer and returns a one-hot winner plus an any-valid flag.

Test Plan:
- Single requester: req[0] high for 13 cycles writing 240..251 -> gnt[0] rises 1 cycle after req. mem_we/mem_addr follow the placer each cycle, and gnt[0] falls 1 cycle after req drops.
- Contention from reset: req=3'b111 -> grants go 0, then 1, then 2 as each owner drops req after 4 cycles. There is no idle cycle between owners and gnt is one-hot throughout.
- Fairness: after requester 2 releases with req=3'b111 pending -> the next grant goes to 0, not 1.
- Reads: owner issues reads at 10, 11, 12 with mem_rdata modelled -> rvalid[owner] is high for 3 consecutive cycles, each one cycle after its address. rdata matches the memory model.
- Watchdog: HOLD_MAX=64 and req[1] held continuously with req[0] also pending -> gnt[1] drops after 64 granted cycles and timeout_err pulses once. gnt[0] asserts 2 cycles later.
- Reset mid-burst: rst asserted during the placer's 6th write -> gnt=0 and mem_we=0 on the reset edge, and state returns to IDLE with pointer 0.

Source files
------------

// File: rtl/grid_mem_arbiter_pkg.sv
// grid_mem_arbiter_pkg -- shared constants and FSM encoding for the grid memory arbiter.
// Rev 1.0
`default_nettype none

package grid_mem_arbiter_pkg;

  localparam int NUM_REQ              = 3;
  localparam int REQ_PLACER           = 0;
  localparam int REQ_MOVER            = 1;
  localparam int REQ_CLEAR            = 2;
  localparam int GRID_ADDR_W          = 8;
  localparam int GRID_DATA_W          = 8;
  localparam int NEXT_PIECE_BASE_ADDR = 240;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/grid_mem_arbiter_rr_pick.sv
// grid_mem_arbiter_rr_pick -- combinational round-robin picker, search from ptr upward with wrap.
// Rev 1.0
`default_nettype none

module grid_mem_arbiter_rr_pick
  import grid_mem_arbiter_pkg::*;
#(
  parameter int N_REQ = NUM_REQ,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] win,
  output logic             any
);

  int idx;

  always_comb begin
    win = '0;
    any = 1'b0;
    idx = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any && req[idx]) begin
        win[idx] = 1'b1;
        any      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/grid_mem_arbiter.sv
// grid_mem_arbiter -- round-robin burst arbiter for the single-port grid memory with hold watchdog.
// Rev 1.0
`default_nettype none

module grid_mem_arbiter
  import grid_mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int ADDR_W   = GRID_ADDR_W,
  parameter int DATA_W   = GRID_DATA_W,
  parameter int HOLD_MAX = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_data,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [DATA_W-1:0]         rdata,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic                      timeout_err
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(HOLD_MAX + 1);

  arb_state_t         state, state_nx;
  logic [NUM_REQ-1:0] gnt_nx, pick_req, pick_win;
  logic               pick_any;
  logic [PTR_W-1:0]   ptr, ptr_nx, owner, owner_inc, pick_ptr;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               owner_req, timeout_nx;

  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) owner = PTR_W'(i);
    end
  end

  assign owner_inc = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);
  assign owner_req = |(req & gnt);

  // While owning, the owner is masked out so its release-cycle request is ignored.
  assign pick_req = (state == ST_OWN) ? (req & ~gnt) : req;
  assign pick_ptr = (state == ST_OWN) ? owner_inc : ptr;

  grid_mem_arbiter_rr_pick #(
    .N_REQ (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req (pick_req),
    .ptr (pick_ptr),
    .win (pick_win),
    .any (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      gnt         <= '0;
      cnt         <= '0;
      ptr         <= '0;
      timeout_err <= 1'b0;
      rvalid      <= '0;
    end else begin
      state       <= state_nx;
      gnt         <= gnt_nx;
      cnt         <= cnt_nx;
      ptr         <= ptr_nx;
      timeout_err <= timeout_nx;
      rvalid      <= gnt & req & ~req_we;
    end
  end

  always_comb begin
    state_nx   = state;
    gnt_nx     = gnt;
    cnt_nx     = cnt;
    ptr_nx     = ptr;
    timeout_nx = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_nx   = pick_win;
          state_nx = ST_OWN;
          cnt_nx   = CNT_W'(1);
        end
      end
      ST_OWN: begin
        if (!owner_req) begin
          ptr_nx = owner_inc;
          if (pick_any) begin
            gnt_nx = pick_win;
            cnt_nx = CNT_W'(1);
          end else begin
            gnt_nx   = '0;
            cnt_nx   = '0;
            state_nx = ST_IDLE;
          end
        end else if (cnt == CNT_W'(HOLD_MAX)) begin
          gnt_nx     = '0;
          cnt_nx     = '0;
          ptr_nx     = owner_inc;
          timeout_nx = 1'b1;
          state_nx   = ST_IDLE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = ST_IDLE;
        gnt_nx   = '0;
        cnt_nx   = '0;
      end
    endcase
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        mem_we   = req[i] & req_we[i];
        mem_addr = req_addr[i*ADDR_W +: ADDR_W];
        mem_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign rdata = mem_rdata;

endmodule

`default_nettype wire
